// File: rtl/pool_window_buffer.sv
// 2x2 stride-2 window former for a row-major pixel stream.
// Even rows fill a line buffer; odd rows pair with it to emit windows.
module pool_window_buffer #(
  parameter int BITWIDTH = 8,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITWIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*BITWIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [BITWIDTH-1:0]   r_line [WIDTH];
  logic [BITWIDTH-1:0]   r_prev;
  logic [4*BITWIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_last;
  logic                  r_frame_done;

  logic          w_xfer;
  logic          w_fire;
  logic          w_win;
  logic          w_col_end;
  logic          w_row_end;
  logic [CW-1:0] w_col_l;

  assign in_ready   = !r_out_valid || out_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

  assign w_xfer    = in_valid && in_ready;
  assign w_fire    = r_out_valid && out_ready;
  assign w_win     = w_xfer && r_row[0] && r_col[0];
  assign w_col_end = (r_col == COL_LAST);
  assign w_row_end = (r_row == ROW_LAST);
  assign w_col_l   = r_col - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_prev       <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fire && r_last;
      if (w_xfer) begin
        r_col <= w_col_end ? '0 : r_col + CW'(1);
        if (w_col_end)
          r_row <= w_row_end ? '0 : r_row + RW'(1);
        if (!r_col[0])
          r_prev <= in_data;
      end
      // a new window may land on the same edge the old one drains
      if (w_win) begin
        r_out_valid <= 1'b1;
        r_out_data  <= {in_data, r_prev,
                        r_line[r_col], r_line[w_col_l]};
        r_last      <= w_row_end && w_col_end;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_xfer && !r_row[0])
      r_line[r_col] <= in_data;
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Scoreboard bench: 4x2 instance for directed/bubble cases,
// 28x28 instance for back-to-back frames.
module tb_pool_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  in_data_a;
  logic        in_valid_a, in_ready_a;
  logic [31:0] out_data_a;
  logic        ov_a, fd_a, out_ready_a;
  logic        dir_ready, rnd_mode, rnd_bit;

  assign out_ready_a = rnd_mode ? rnd_bit : dir_ready;

  pool_window_buffer #(.BITWIDTH(8), .WIDTH(4), .HEIGHT(2)) u_a (
    .clk(clk), .rst(rst),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(ov_a), .out_ready(out_ready_a),
    .frame_done(fd_a)
  );

  logic [7:0]  in_data_b;
  logic        in_valid_b, in_ready_b;
  logic [31:0] out_data_b;
  logic        ov_b, fd_b, out_ready_b;

  pool_window_buffer #(.BITWIDTH(8), .WIDTH(28), .HEIGHT(28)) u_b (
    .clk(clk), .rst(rst),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(ov_b), .out_ready(out_ready_b),
    .frame_done(fd_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;

  exp_t        qa[$];
  logic [31:0] qb[$];
  bit          pend_a = 0;
  bit          pend_b = 0;
  int          win_b = 0;
  int          fd_cnt_b = 0;
  logic [7:0]  img [0:1][0:3];

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) begin
      qa.delete();
      pend_a = 0;
    end else begin
      checks++;
      if (fd_a !== pend_a) begin
        errors++;
        $display("FAIL frame_done_a got %b want %b", fd_a, pend_a);
      end
      pend_a = 0;
      if (ov_a && out_ready_a) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL win_a got %h want none", out_data_a);
        end else begin
          e = qa.pop_front();
          if (out_data_a !== e.d) begin
            errors++;
            $display("FAIL win_a got %h want %h", out_data_a, e.d);
          end
          pend_a = e.last;
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [31:0] w;
    if (!rst) begin
      checks++;
      if (fd_b !== pend_b) begin
        errors++;
        $display("FAIL frame_done_b got %b want %b", fd_b, pend_b);
      end
      if (fd_b) fd_cnt_b++;
      pend_b = 0;
      if (ov_b && out_ready_b) begin
        checks++;
        win_b++;
        pend_b = (win_b % 196 == 0);
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL win_b got %h want none", out_data_b);
        end else begin
          w = qb.pop_front();
          if (out_data_b !== w) begin
            errors++;
            $display("FAIL win_b got %h want %h", out_data_b, w);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    qa.push_back(e);
  endtask

  task automatic send_a(input logic [7:0] p, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data_a  = p;
    in_valid_a = 1'b1;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready_a) begin
      checks++;
      errors++;
      $display("FAIL send_a_timeout got stalled want accept %h", p);
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_img_a();
    for (int wc = 0; wc < 2; wc++)
      push_a({img[1][2*wc+1], img[1][2*wc],
              img[0][2*wc+1], img[0][2*wc]}, wc == 1);
  endtask

  task automatic send_img_a(input bit gaps);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        send_a(img[r][c], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  function automatic logic [7:0] pixb(input int f, input int r,
                                      input int c);
    int v;
    v = f * 7 + r * 28 + c;
    return v[7:0];
  endfunction

  initial begin
    int n;
    rst         = 1'b1;
    in_data_a   = '0;
    in_valid_a  = 1'b0;
    dir_ready   = 1'b1;
    rnd_mode    = 1'b0;
    rnd_bit     = 1'b0;
    in_data_b   = '0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(ov_a), 0);
    chk("rst_frame_done", 32'(fd_a), 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_in_ready", 32'(in_ready_a), 1);
    @(posedge clk);
    #1;

    // basic 4x2 window
    push_a(32'h06050201, 0);
    push_a(32'h08070403, 1);
    for (int i = 1; i <= 5; i++) send_a(8'(i), 0);
    send_a(8'd6, 0);
    chk("lat1_valid", 32'(ov_a), 1);
    chk("lat1_data", out_data_a, 32'h06050201);
    send_a(8'd7, 0);
    send_a(8'd8, 0);
    chk("lat2_data", out_data_a, 32'h08070403);
    @(posedge clk);
    #1;
    chk("frame_done_pulse", 32'(fd_a), 1);
    idle(3);

    // backpressure
    push_a(32'h06050201, 0);
    push_a(32'h08070403, 1);
    dir_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_a(8'(i), 0);
    in_data_a  = 8'd7;
    in_valid_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready_a), 0);
      chk("bp_hold_data", out_data_a, 32'h06050201);
      chk("bp_hold_valid", 32'(ov_a), 1);
    end
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    send_a(8'd7, 0);
    dir_ready = 1'b0;
    send_a(8'd8, 0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold2_data", out_data_a, 32'h08070403);
    end
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    idle(3);

    // signed pass-through
    push_a(32'h00FF7F80, 0);
    push_a(32'h281E140A, 1);
    send_a(8'h80, 0); send_a(8'h7F, 0);
    send_a(8'h0A, 0); send_a(8'h14, 0);
    send_a(8'hFF, 0); send_a(8'h00, 0);
    chk("signed_data", out_data_a, 32'h00FF7F80);
    send_a(8'h1E, 0); send_a(8'h28, 0);
    idle(3);

    // mid-frame reset with a pending window
    push_a(32'h06050201, 0);
    push_a(32'h08070403, 1);
    for (int i = 1; i <= 6; i++) send_a(8'(i), 0);
    dir_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_out_valid", 32'(ov_a), 0);
    chk("mrst_frame_done", 32'(fd_a), 0);
    chk("mrst_in_ready", 32'(in_ready_a), 1);
    dir_ready = 1'b1;
    push_a(32'h06050201, 0);
    push_a(32'h08070403, 1);
    for (int i = 1; i <= 8; i++) send_a(8'(i), 0);
    idle(3);

    // bubbles and random backpressure
    rnd_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 4; c++)
          img[r][c] = 8'($urandom);
      push_img_a();
      send_img_a(1);
    end
    rnd_mode = 1'b0;
    n = 0;
    while (qa.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("drain_a", 32'(qa.size()), 0);
    idle(3);

    // two back-to-back 28x28 frames
    for (int f = 0; f < 2; f++)
      for (int wr = 0; wr < 14; wr++)
        for (int wc = 0; wc < 14; wc++)
          qb.push_back({pixb(f, 2*wr+1, 2*wc+1), pixb(f, 2*wr+1, 2*wc),
                        pixb(f, 2*wr, 2*wc+1), pixb(f, 2*wr, 2*wc)});
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          in_data_b  = pixb(f, r, c);
          in_valid_b = 1'b1;
          @(negedge clk);
          if (!in_ready_b) begin
            checks++;
            errors++;
            $display("FAIL b_in_ready got 0 want 1");
          end
          @(posedge clk);
          #1;
        end
    in_valid_b = 1'b0;
    idle(5);
    chk("b_windows", 32'(win_b), 392);
    chk("b_frame_done_count", 32'(fd_cnt_b), 2);
    chk("b_queue_empty", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_window_buffer.md
POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: bits per signed pixel.
REQ-002 SHALL have parameter WIDTH, default 28: pixels per feature-map row. Must be even and at least 2.
REQ-003 SHALL have parameter HEIGHT, default 28: rows per feature map. Must be even and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, BITWIDTH bits: signed pixel, row-major stream order.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-009 SHALL have port out_data, output, 4*BITWIDTH bits: packed 2x2 window that feeds the downstream Avg stage (LENGTH=4).
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a complete window.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the window this cycle.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last window of a frame is accepted downstream.

Function
REQ-013 SHALL transfer an input pixel only in a cycle where in_valid and in_ready are both 1.
REQ-014 SHALL keep column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), and advance them by one pixel per input transfer.
- col wraps to 0 after WIDTH-1, and row increments at that wrap.
- row wraps to 0 after HEIGHT-1, with no idle cycle between frames.
REQ-015 SHALL, on even rows, write each accepted pixel into a WIDTH-entry line buffer at index col.
REQ-016 SHALL, on any row, hold the pixel accepted at an even col in a register prev_pix.
REQ-017 SHALL complete a window on an odd row at an odd col (the accepted pixel is P) and load out_data as follows:
- bits [BITWIDTH-1:0] = linebuf[col-1] (top-left)
- bits [2*BITWIDTH-1:BITWIDTH] = linebuf[col] (top-right)
- bits [3*BITWIDTH-1:2*BITWIDTH] = prev_pix (bottom-left)
- bits [4*BITWIDTH-1:3*BITWIDTH] = P (bottom-right)
REQ-018 SHALL set out_valid on the clock edge that accepts P, giving a latency of 1 cycle from P's transfer to out_valid.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid on an edge where out_valid=1 and out_ready=1, unless a new window completes on the same edge; in that case out_valid stays 1 and out_data loads the new window.
REQ-021 SHALL drive in_ready = !out_valid || out_ready (combinational), so no window is ever overwritten or dropped.
REQ-022 SHALL pulse frame_done for exactly one cycle, on the cycle after the downstream accepts the window whose P was pixel (HEIGHT-1, WIDTH-1).
REQ-023 SHALL emit exactly (WIDTH/2)*(HEIGHT/2) windows per frame, in raster order of window position.
REQ-024 SHALL leave counters and buffers unchanged in cycles with no input transfer.
REQ-025 SHALL pass pixel values through bit-exact with no arithmetic; signedness is preserved for the downstream Avg stage.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set col=0, row=0, out_valid=0, out_data=0, frame_done=0, prev_pix=0.
REQ-027 SHALL not require line-buffer contents to be reset; even rows always overwrite the entries before they are read.
REQ-028 SHALL, on a reset asserted mid-frame, discard the partial frame and any pending window; the first pixel accepted after reset is treated as pixel (0,0).
REQ-029 SHALL present in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL pass the basic window check:
- Stimulus: WIDTH=4, HEIGHT=2, out_ready held 1, stream row0 = 1,2,3,4 and row1 = 5,6,7,8 (one pixel per cycle).
- Response: window {1,2,5,6} one cycle after pixel 6, then {3,4,7,8} one cycle after pixel 8.
- Response: frame_done pulses one cycle after the {3,4,7,8} handshake.
REQ-031 SHALL pass the backpressure check:
- Stimulus: hold out_ready=0 after the first window completes.
- Response: in_ready=0, out_data stays {1,2,5,6}, and no input is accepted.
- Stimulus: raise out_ready for one cycle.
- Response: the window is consumed and streaming resumes with no data loss.
REQ-032 SHALL pass the signed-value check:
- Stimulus: stream pixels -128, 127, -1, 0 at window positions TL, TR, BL, BR.
- Response: out_data = 0x00FF7F80 at BITWIDTH=8.
REQ-033 SHALL pass the back-to-back frames check:
- Stimulus: two consecutive 28x28 frames with no gap.
- Response: exactly 196 windows per frame, and frame_done pulses exactly twice.
REQ-034 SHALL pass the mid-frame reset check:
- Stimulus: assert rst for one cycle during row 1, col 1, while out_valid=1.
- Response: out_valid=0 and frame_done=0 the next cycle.
- Response: a fresh 4x2 frame afterwards produces the same windows as in REQ-030.
REQ-035 SHALL pass the bubble check:
- Stimulus: random in_valid gaps with random out_ready.
- Response: the window sequence matches a reference model's 2x2 stride-2 raster order exactly.
